// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, the STP opcode and the boot address.
package cpu_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2,
      HALT = 2'd3
   } state_t;

   localparam logic [4:0]  OP_STP            = 5'b11111;
   localparam logic [15:0] BOOT_ADDR_DEFAULT = 16'h0000;

endpackage

// File: rtl/pc_reg.sv
// 16-bit program counter. Load has priority over increment, and increment wraps.
// Nothing changes unless the current instruction retires.
module pc_reg #(
   parameter logic [15:0] RESET_VAL = 16'h0001
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        en,
   input  logic        sload,
   input  logic        inc,
   input  logic [15:0] load_val,
   output logic [15:0] pc
);

   // Load/increment/hold of the pc on retiring cycles.
   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc <= RESET_VAL;
      end else if (en) begin
         if (sload) begin
            pc <= load_val;
         end else if (inc) begin
            pc <= pc + 16'd1;
         end
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: boot, run/wait/halt and single-step control. Owns the pc
// and the retired-instruction counter, and steers the instruction memory addresses.
module fetch_sequencer
   import cpu_pkg::*;
#(
   parameter logic [15:0] BOOT_ADDR = BOOT_ADDR_DEFAULT,
   parameter int          CNT_W     = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             run_en,
   input  logic             step_req,
   input  logic             cnt_en,
   input  logic             pc_sload,
   input  logic [15:0]      new_pc,
   input  logic [15:0]      dec_addr1,
   input  logic [15:0]      dec_addr2,
   input  logic [15:0]      mem_q1,
   input  logic [15:0]      mem_q2,
   output logic [15:0]      pc,
   output logic [15:0]      instr,
   output logic [15:0]      N,
   output logic [15:0]      mem_addr1,
   output logic [15:0]      mem_addr2,
   output logic             retire,
   output logic             halted,
   output logic [CNT_W-1:0] instr_cnt
);

   state_t      state;
   state_t      next_state;
   logic        step_pending;
   logic        next_step_pending;
   logic [15:0] held_addr1;
   logic [15:0] held_addr2;
   logic        is_stp;

   // The memory already has a cycle of latency, so read data goes straight to the decoder.
   assign instr  = mem_q1;
   assign N      = mem_q2;
   assign is_stp = (mem_q1[15:11] == OP_STP);
   assign halted = (state == HALT);

   pc_reg #(
      .RESET_VAL (BOOT_ADDR + 16'd1)
   ) u_pc_reg (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (retire),
      .sload    (pc_sload),
      .inc      (cnt_en),
      .load_val (new_pc),
      .pc       (pc)
   );

   // Next state, step tracking, retire and address steering.
   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      next_state        = state;
      next_step_pending = step_pending;
      retire            = 1'b0;
      mem_addr1         = held_addr1;
      mem_addr2         = held_addr2;
      case (state)
         BOOT: begin
            mem_addr1  = BOOT_ADDR;
            mem_addr2  = BOOT_ADDR + 16'd1;
            next_state = run_en ? RUN : WAIT;
         end
         RUN: begin
            mem_addr1 = dec_addr1;
            mem_addr2 = dec_addr2;
            if (is_stp) begin
               // STP never commits; the core parks in HALT.
               next_state        = HALT;
               next_step_pending = 1'b0;
            end else begin
               retire = 1'b1;
               if (!run_en || step_pending) begin
                  next_state        = WAIT;
                  next_step_pending = 1'b0;
               end
            end
         end
         WAIT: begin
            // Free-run wins over a simultaneous step request.
            if (run_en) begin
               next_state = RUN;
            end else if (step_req) begin
               next_state        = RUN;
               next_step_pending = 1'b1;
            end
         end
         HALT: begin
            next_state = HALT;
         end
         default: begin
            next_state = BOOT;
         end
      endcase
   end

   // FSM state and single-step flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= BOOT;
         step_pending <= 1'b0;
      end else begin
         state        <= next_state;
         step_pending <= next_step_pending;
      end
   end

   // Remember the last decoder addresses so WAIT and HALT re-present the current instruction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         held_addr1 <= BOOT_ADDR;
         held_addr2 <= BOOT_ADDR + 16'd1;
      end else if (state == RUN) begin
         held_addr1 <= dec_addr1;
         held_addr2 <= dec_addr2;
      end
   end

   // Retired-instruction counter, wrapping at 2^CNT_W.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr_cnt <= '0;
      end else if (retire) begin
         instr_cnt <= instr_cnt + CNT_W'(1);
      end
   end

endmodule
